// File: rtl/lfsr_stream_gen.sv
// Fibonacci LFSR advancing STEP bits per cycle, delivered over a valid/ready stream.
// Supports runtime reseed, zero-seed protection, lock-up recovery and a period-wrap pulse.
module lfsr_stream_gen #(
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
  parameter int unsigned      STEP  = 6,
  parameter logic [WIDTH-1:0] INIT  = 16'hBEEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             seed_vld,
  input  logic [WIDTH-1:0] seed,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [STEP-1:0]  out,
  output logic [WIDTH-1:0] state,
  output logic             wrap,
  output logic             lock_err,
  output logic             seed_err
);

  typedef enum logic {FILL, RUN} fsm_t;

  fsm_t             fsm_q, fsm_d;
  logic [WIDTH-1:0] start_q;
  logic [WIDTH-1:0] nxt_raw;
  logic [WIDTH-1:0] nxt_state;
  logic [WIDTH-1:0] seed_fix;
  logic [STEP-1:0]  chunk;
  logic             fb;
  logic             adv;
  logic             fire;
  logic             nxt_zero;

  assign out_vld = (fsm_q == RUN);
  assign fire    = out_vld & out_rdy;

  // Unrolled STEP single steps; the first generated bit lands in the chunk MSB.
  always_comb begin
    nxt_raw = state;
    chunk   = '0;
    fb      = 1'b0;
    for (int unsigned i = 0; i < STEP; i++) begin
      fb      = ^(nxt_raw & TAPS);
      nxt_raw = {nxt_raw[WIDTH-2:0], fb};
      chunk   = STEP'({chunk, fb});
    end
  end

  assign nxt_zero  = (nxt_raw == '0);
  assign nxt_state = nxt_zero ? INIT : nxt_raw;
  assign seed_fix  = (seed == '0) ? INIT : seed;

  always_comb begin
    fsm_d = fsm_q;
    adv   = 1'b0;
    if (seed_vld) begin
      fsm_d = FILL;
    end else begin
      case (fsm_q)
        FILL: begin
          if (en) begin
            adv   = 1'b1;
            fsm_d = RUN;
          end
        end
        RUN: begin
          if (fire) begin
            if (en) adv = 1'b1;
            else    fsm_d = FILL;
          end
        end
        default: fsm_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q    <= FILL;
      state    <= INIT;
      start_q  <= INIT;
      out      <= '0;
      wrap     <= 1'b0;
      lock_err <= 1'b0;
      seed_err <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      wrap     <= 1'b0;
      lock_err <= 1'b0;
      if (seed_vld) begin
        state   <= seed_fix;
        start_q <= seed_fix;
        if (seed == '0) seed_err <= 1'b1;
      end else if (adv) begin
        out      <= chunk;
        state    <= nxt_state;
        wrap     <= (nxt_state == start_q);
        lock_err <= nxt_zero;
        if (nxt_zero) start_q <= INIT;
      end
    end
  end

endmodule

// File: tb/tb_lfsr_stream_gen.sv
// Directed bench for lfsr_stream_gen: cycle model feeds a scoreboard queue,
// plus a second instance with degenerate taps to exercise lock-up recovery.
module tb_lfsr_stream_gen;

  localparam logic [15:0] INIT = 16'hBEEF;

  typedef struct packed {
    logic        vld;
    logic [5:0]  out;
    logic [15:0] state;
    logic        wrap;
    logic        lock;
    logic        serr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1, en = 1'b0, seed_vld = 1'b0, out_rdy = 1'b0;
  logic [15:0] seed = '0;
  logic        out_vld, wrap, lock_err, seed_err;
  logic [5:0]  dout;
  logic [15:0] state;

  logic        l_rst = 1'b1, l_en = 1'b0, l_seed_vld = 1'b0, l_rdy = 1'b0;
  logic [15:0] l_seed = '0;
  logic        l_vld, l_wrap, l_lock, l_serr;
  logic [0:0]  l_out;
  logic [15:0] l_state;

  int vectors = 0;
  int errors  = 0;
  int n_adv   = 0;

  exp_t        q[$];
  logic [15:0] m_state = INIT, m_start = INIT;
  logic [5:0]  m_out = '0;
  logic        m_vld = 1'b0, m_serr = 1'b0;

  always #5 clk = ~clk;

  lfsr_stream_gen #(.WIDTH(16), .TAPS(16'hB400), .STEP(6), .INIT(16'hBEEF)) u0 (
    .clk(clk), .rst(rst), .en(en), .seed_vld(seed_vld), .seed(seed),
    .out_vld(out_vld), .out_rdy(out_rdy), .out(dout), .state(state),
    .wrap(wrap), .lock_err(lock_err), .seed_err(seed_err));

  lfsr_stream_gen #(.WIDTH(16), .TAPS(16'h4000), .STEP(1), .INIT(16'hBEEF)) u1 (
    .clk(clk), .rst(l_rst), .en(l_en), .seed_vld(l_seed_vld), .seed(l_seed),
    .out_vld(l_vld), .out_rdy(l_rdy), .out(l_out), .state(l_state),
    .wrap(l_wrap), .lock_err(l_lock), .seed_err(l_serr));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Six single LFSR steps, collecting each feedback bit MSB-first.
  task automatic model_adv(input logic [15:0] s, output logic [5:0] c, output logic [15:0] ns);
    logic b;
    c = '0;
    for (int i = 0; i < 6; i++) begin
      b = ^(s & 16'hB400);
      s = {s[14:0], b};
      c = {c[4:0], b};
    end
    ns = s;
  endtask

  task automatic step();
    exp_t        e;
    logic [5:0]  c;
    logic [15:0] ns;
    e = '0;
    if (rst) begin
      m_state = INIT; m_start = INIT; m_out = '0; m_vld = 1'b0; m_serr = 1'b0;
    end else if (seed_vld) begin
      m_state = (seed == 16'h0) ? INIT : seed;
      m_start = m_state;
      m_vld   = 1'b0;
      if (seed == 16'h0) m_serr = 1'b1;
    end else if (en && (!m_vld || out_rdy)) begin
      model_adv(m_state, c, ns);
      m_out = c;
      if (ns == 16'h0) begin
        e.lock = 1'b1;
        ns = INIT;
      end
      e.wrap = (ns == m_start);
      if (e.lock) m_start = INIT;
      m_state = ns;
      m_vld   = 1'b1;
      n_adv++;
    end else if (m_vld && out_rdy) begin
      m_vld = 1'b0;
    end
    e.vld = m_vld; e.out = m_out; e.state = m_state; e.serr = m_serr;
    q.push_back(e);
    @(posedge clk); #1;
    e = q.pop_front();
    check("out_vld",  32'(out_vld),  32'(e.vld));
    check("out",      32'(dout),     32'(e.out));
    check("state",    32'(state),    32'(e.state));
    check("wrap",     32'(wrap),     32'(e.wrap));
    check("lock_err", 32'(lock_err), 32'(e.lock));
    check("seed_err", 32'(seed_err), 32'(e.serr));
  endtask

  initial begin
    // reset
    step(); step();
    check("rst_state", 32'(state), 32'hBEEF);
    check("rst_out",   32'(dout),  32'h0);
    rst = 1'b0;

    // first chunk, then backpressure hold
    en = 1'b1; out_rdy = 1'b0;
    step();
    check("first_out",   32'(dout),    32'h1B);
    check("first_state", 32'(state),   32'hBBDB);
    check("first_vld",   32'(out_vld), 32'h1);
    repeat (5) step();
    check("hold_out",   32'(dout),  32'h1B);
    check("hold_state", 32'(state), 32'hBBDB);
    out_rdy = 1'b1;
    step();

    // mixed enable / ready traffic
    for (int i = 0; i < 40; i++) begin
      en      = 1'($urandom_range(0, 1));
      out_rdy = 1'($urandom_range(0, 1));
      step();
    end

    // zero seed falls back to INIT and sets sticky error
    seed_vld = 1'b1; seed = 16'h0; en = 1'b1;
    step();
    seed_vld = 1'b0;
    check("zseed_state", 32'(state),    32'hBEEF);
    check("zseed_err",   32'(seed_err), 32'h1);
    check("zseed_vld",   32'(out_vld),  32'h0);

    // pending chunk discarded by reseed, then full period wrap
    out_rdy = 1'b0;
    step(); step();
    seed_vld = 1'b1; seed = 16'h0001; out_rdy = 1'b1;
    step();
    seed_vld = 1'b0;
    n_adv = 0;
    for (int i = 0; i < 22000; i++) begin
      step();
      if (wrap) break;
    end
    check("wrap_advances", 32'(n_adv), 32'd21845);
    check("serr_sticky",   32'(seed_err), 32'h1);

    // reset while stalled with a valid chunk
    out_rdy = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    check("mid_rst_vld",  32'(out_vld),  32'h0);
    check("mid_rst_out",  32'(dout),     32'h0);
    check("mid_rst_st",   32'(state),    32'hBEEF);
    check("mid_rst_serr", 32'(seed_err), 32'h0);
    // reset beats a simultaneous seed load
    seed_vld = 1'b1; seed = 16'h1234;
    step();
    seed_vld = 1'b0; rst = 1'b0;
    check("rst_vs_seed", 32'(state), 32'hBEEF);

    // lock-up recovery on the degenerate-tap instance
    @(posedge clk); #1;
    l_rst = 1'b0; l_seed_vld = 1'b1; l_seed = 16'h8000;
    @(posedge clk); #1;
    check("l_seed", 32'(l_state), 32'h8000);
    l_seed_vld = 1'b0; l_en = 1'b1; l_rdy = 1'b1;
    @(posedge clk); #1;
    check("l_lock",  32'(l_lock),  32'h1);
    check("l_out",   32'(l_out),   32'h0);
    check("l_state", 32'(l_state), 32'hBEEF);
    check("l_vld",   32'(l_vld),   32'h1);
    @(posedge clk); #1;
    check("l_lock_pulse", 32'(l_lock),  32'h0);
    check("l_state2",     32'(l_state), 32'h7DDE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
